// File: rtl/byte_unrotate_pipe_if.sv
// Valid/ready bundle for the lane un-rotator: upstream word + amount in, un-rotated word out.
interface byte_unrotate_pipe_if #(
    parameter int N = 8,
    parameter int S = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [N*8-1:0]   in_data;
    logic [S-1:0]     in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [N*8-1:0]   out_data;
    logic [S-1:0]     out_amt;
    logic [S:0]       occupancy;

    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, out_amt, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, out_amt, occupancy
    );
endinterface

// File: rtl/byte_unrotate_pipe.sv
// S-stage pipelined lane un-rotator: out lane i = in lane (i - amt) mod N.
// Stage k applies a 2^k-lane right rotate when amt bit k is set; stalls collapse bubbles.
module byte_unrotate_pipe #(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic clk,
    input  logic reset,
    byte_unrotate_pipe_if.slave bus
);
    localparam int W = N * 8;

    logic [S-1:0] valid_reg;
    logic [W-1:0] data_reg [S];
    logic [S-1:0] amt_reg [S];
    logic [S:0]   occupancy_reg;

    logic [S-1:0] load;
    logic [S-1:0] valid_src;
    logic [S-1:0] valid_next;
    logic [S:0]   occupancy_next;
    logic [W-1:0] data_src [S];
    logic [S-1:0] amt_src [S];
    logic [W-1:0] data_rot [S];

    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_stage
            localparam int SH = (1 << gi) * 8;
            if (gi == 0) begin : g_head
                assign data_src[gi]  = bus.in_data;
                assign amt_src[gi]   = bus.in_amt;
                assign valid_src[gi] = bus.in_valid;
            end else begin : g_body
                assign data_src[gi]  = data_reg[gi-1];
                assign amt_src[gi]   = amt_reg[gi-1];
                assign valid_src[gi] = valid_reg[gi-1];
            end
            // Top SH bits wrap into the low lanes: lane i takes lane (i - 2^gi).
            assign data_rot[gi] = amt_src[gi][gi]
                                ? {data_src[gi][W-SH-1:0], data_src[gi][W-1:W-SH]}
                                : data_src[gi];
        end
    endgenerate

    // A stage loads when it is empty or its contents leave; evaluated from the output backward.
    always_comb begin
        load           = '0;
        valid_next     = valid_reg;
        occupancy_next = '0;
        load[S-1]      = !valid_reg[S-1] || bus.out_ready;
        for (int k = S - 2; k >= 0; k--) begin
            load[k] = !valid_reg[k] || load[k+1];
        end
        for (int k = 0; k < S; k++) begin
            if (load[k]) begin
                valid_next[k] = valid_src[k];
            end
            occupancy_next = occupancy_next + {{S{1'b0}}, valid_next[k]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg     <= '0;
            occupancy_reg <= '0;
            for (int k = 0; k < S; k++) begin
                data_reg[k] <= '0;
                amt_reg[k]  <= '0;
            end
        end else begin
            valid_reg     <= valid_next;
            occupancy_reg <= occupancy_next;
            for (int k = 0; k < S; k++) begin
                if (load[k] && valid_src[k]) begin
                    data_reg[k] <= data_rot[k];
                    amt_reg[k]  <= amt_src[k];
                end
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = valid_reg[S-1];
    assign bus.out_data  = data_reg[S-1];
    assign bus.out_amt   = amt_reg[S-1];
    assign bus.occupancy = occupancy_reg;
endmodule

// File: tb/tb_byte_unrotate_pipe.sv
// Self-checking bench for byte_unrotate_pipe (N=8, S=3): directed scenarios plus random traffic
// against a lane-indexing reference model and an in-flight word queue.
module tb_byte_unrotate_pipe;
    localparam int N = 8;
    localparam int S = 3;

    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  a;
    } word_t;

    logic clk;
    logic reset;

    byte_unrotate_pipe_if #(.N(N), .S(S)) bus ();

    byte_unrotate_pipe #(.N(N), .S(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    word_t       q[$];
    bit          held     = 1'b0;
    word_t       held_w;
    logic [63:0] last_data;
    logic [2:0]  last_amt;
    int          run_len  = 0;
    int          max_run  = 0;
    bit          acc;
    int          idx;
    logic [63:0] bp_d [4];
    logic [2:0]  bp_a [4];

    function automatic logic [63:0] unrot(input logic [63:0] d, input int amt);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[8*i +: 8] = d[8*(((i - amt) % N + N) % N) +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input logic [2:0] a);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_amt   = a;
    endtask

    task automatic drive_idle();
        drive(1'b0, rnd64(), 3'($urandom_range(0, 7)));
    endtask

    // One clock: sample at the falling edge, score emits/accepts, then resume 1ns past the rising edge.
    task automatic step(input int exp_ov, output bit accepted);
        word_t w;
        @(negedge clk);
        check("occupancy", 64'(bus.occupancy), 64'(q.size()));
        check("in_ready", 64'(bus.in_ready), 64'((q.size() < S) || bus.out_ready));
        if (exp_ov >= 0) check("latency_out_valid", 64'(bus.out_valid), 64'(exp_ov));
        if (held) begin
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_out_data", bus.out_data, held_w.d);
            check("stall_out_amt", 64'(bus.out_amt), 64'(held_w.a));
        end
        if (bus.out_valid && bus.out_ready) begin
            check("emit_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                w = q.pop_front();
                check("out_data", bus.out_data, unrot(w.d, int'(w.a)));
                check("out_amt", 64'(bus.out_amt), 64'(w.a));
            end
            last_data = bus.out_data;
            last_amt  = bus.out_amt;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            $display("emit   data=%h amt=%0d occ=%0d", bus.out_data, bus.out_amt, bus.occupancy);
        end else begin
            run_len = 0;
        end
        held     = bus.out_valid && !bus.out_ready;
        held_w   = '{bus.out_data, bus.out_amt};
        accepted = bus.in_valid && bus.in_ready;
        if (accepted) begin
            q.push_back('{bus.in_data, bus.in_amt});
            $display("accept data=%h amt=%0d occ=%0d", bus.in_data, bus.in_amt, bus.occupancy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        drive_idle();
        for (int k = 0; k < 20 && q.size() != 0; k++) step(-1, acc);
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Single word on an empty pipe: out_valid must rise exactly S cycles after acceptance.
    task automatic single(input logic [63:0] d, input logic [2:0] a, input logic [63:0] exp);
        bus.out_ready = 1'b1;
        drive(1'b1, d, a);
        step(-1, acc);
        check("single_accept", 64'(acc), 64'd1);
        drive_idle();
        step(0, acc);
        step(0, acc);
        step(1, acc);
        check("single_data", last_data, exp);
        check("single_amt", 64'(last_amt), 64'(a));
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset         = 1'b0;
        bus.out_ready = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_occupancy", 64'(bus.occupancy), 64'd0);
        check("reset_out_data", bus.out_data, 64'd0);
        check("reset_out_amt", 64'(bus.out_amt), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic and edge amounts.
        single(64'h0706050403020100, 3'd3, 64'h0403020100070605);
        single(64'h0706050403020100, 3'd0, 64'h0706050403020100);
        single(64'h0706050403020100, 3'd7, 64'h0007060504030201);

        // Streaming: 16 back-to-back words.
        bus.out_ready = 1'b1;
        run_len = 0;
        max_run = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, rnd64(), 3'(i % 8));
            step(-1, acc);
            check("stream_accept", 64'(acc), 64'd1);
            if (i >= 2) check("stream_occupancy", 64'(bus.occupancy), 64'd3);
        end
        drain();
        check("stream_run", 64'(max_run), 64'd16);

        // Backpressure: four words offered against a stalled output.
        for (int i = 0; i < 4; i++) begin
            bp_d[i] = rnd64();
            bp_a[i] = 3'($urandom_range(0, 7));
        end
        bus.out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            if (idx < 4) drive(1'b1, bp_d[idx], bp_a[idx]);
            else drive_idle();
            step(-1, acc);
            if (acc) idx++;
        end
        check("bp_accepted", 64'(idx), 64'd3);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_occupancy", 64'(bus.occupancy), 64'd3);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8 && idx < 4; k++) begin
            drive(1'b1, bp_d[idx], bp_a[idx]);
            step(-1, acc);
            if (acc) idx++;
        end
        check("bp_all_accepted", 64'(idx), 64'd4);
        drain();

        // Bubble collapse: A, two idle cycles, then B and C with the output stalled.
        bus.out_ready = 1'b0;
        drive(1'b1, rnd64(), 3'd1);
        step(-1, acc);
        check("bubble_accept_a", 64'(acc), 64'd1);
        drive_idle();
        step(-1, acc);
        step(-1, acc);
        drive(1'b1, rnd64(), 3'd2);
        step(-1, acc);
        check("bubble_accept_b", 64'(acc), 64'd1);
        drive(1'b1, rnd64(), 3'd6);
        step(-1, acc);
        check("bubble_accept_c", 64'(acc), 64'd1);
        drive_idle();
        check("bubble_occupancy", 64'(bus.occupancy), 64'd3);
        run_len = 0;
        max_run = 0;
        drain();
        check("bubble_contiguous", 64'(max_run), 64'd3);

        // Reset asserted between edges with two words in flight.
        bus.out_ready = 1'b0;
        drive(1'b1, rnd64(), 3'd4);
        step(-1, acc);
        drive(1'b1, rnd64(), 3'd5);
        step(-1, acc);
        drive_idle();
        check("pre_reset_occupancy", 64'(bus.occupancy), 64'd2);
        #2 reset = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_reset_occupancy", 64'(bus.occupancy), 64'd0);
        check("async_reset_out_data", bus.out_data, 64'd0);
        check("async_reset_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        held = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        single(64'h0706050403020100, 3'd5, 64'h0201000706050403);

        // Random traffic with random backpressure.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) != 0) drive(1'b1, rnd64(), 3'($urandom_range(0, 7)));
            else drive_idle();
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step(-1, acc);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_unrotate_pipe.md
BYTE_UNROTATE_PIPE -- requirements
Module: byte_unrotate_pipe

Interface
REQ-001 SHALL have parameter N, default 8, giving the number of 8-bit lanes; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter S, default 3, giving the shift-amount width and stage count; S SHALL equal log2(N), and the bench sets both parameters consistently.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream word and amount are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: stage 0 can accept this cycle.
REQ-007 SHALL have port in_data, input, N*8 bits: lane i occupies bits [8i+7:8i].
REQ-008 SHALL have port in_amt, input, S bits: right-rotate amount in lanes.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data and out_amt are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-011 SHALL have port out_data, output, N*8 bits: the un-rotated word.
REQ-012 SHALL have port out_amt, output, S bits: in_amt carried alongside its word.
REQ-013 SHALL have port occupancy, output, S+1 bits: the number of valid stages held.

Function
REQ-014 SHALL transfer a word into the block when in_valid && in_ready, and out of it when out_valid && out_ready.
REQ-015 SHALL compute out lane i = in lane ((i - amt) mod N), the inverse of the existing left-rotate mux array.
REQ-016 SHALL implement S registered stages; stage k holds {valid_k, data_k, amt_k}.
REQ-017 Stage k, for k = 0..S-1, SHALL rotate right by 2^k lanes when amt bit k = 1, and pass the word unchanged otherwise.
REQ-018 Stage k SHALL load from its predecessor when its valid_k = 0, or when its contents move on in the same cycle.
REQ-019 The last stage's contents SHALL move on when out_ready = 1; stage j < S-1 SHALL move on when stage j+1 loads.
REQ-020 When stage k empties without being reloaded, valid_k SHALL clear; the data and amt of an invalid stage are don't-care.
REQ-021 in_ready SHALL equal (valid_0 == 0) OR (stage 0 moves on this cycle), computed combinationally from out_ready backward.
REQ-022 Latency SHALL be exactly S cycles from acceptance to out_valid when out_ready is held at 1.
REQ-023 Throughput SHALL be 1 word per cycle when out_ready is held at 1.
REQ-024 Bubbles SHALL collapse: an empty stage accepts its predecessor even while the stages after it are stalled.
REQ-025 With all stages valid and out_ready = 0, in_ready SHALL be 0 and every stage SHALL hold its contents unchanged.
REQ-026 A simultaneous accept and emit on a full pipe SHALL keep occupancy unchanged, with no loss or duplication of words.
REQ-027 occupancy SHALL equal the sum of all valid_k, registered and updated in the same cycle as the valids.
REQ-028 Word order SHALL be preserved.
REQ-029 out_amt SHALL equal the in_amt accepted with the same word.
REQ-030 in_data and in_amt SHALL be ignored when in_valid = 0.
REQ-031 out_data and out_amt SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-032 An amount of 0 SHALL pass the word through unchanged; wrap-around is modulo N with no saturation.

Reset
REQ-033 reset = 0 SHALL immediately clear all valid_k, set out_valid = 0 and occupancy = 0, and zero out_data and out_amt, regardless of clk.
REQ-034 in_ready SHALL be 1 while reset = 0.
REQ-035 Words in flight when reset is asserted SHALL be discarded.
REQ-036 The first accept after reset is released SHALL occur no earlier than the first rising clk edge with reset = 1.

Verification (N=8, S=3)
REQ-037 Basic: in_data=0x0706050403020100, amt=3, out_ready=1 -> out_data=0x0403020100070605, out_amt=3, out_valid exactly 3 cycles after accept.
REQ-038 Edge amounts: amt=0 -> out_data=0x0706050403020100; amt=7 -> out_data=0x0007060504030201.
REQ-039 Streaming: 16 back-to-back words with amt = 0..7 repeated, out_ready=1 -> 16 consecutive out_valid cycles, each matching the reference model, in order, with occupancy steady at 3.
REQ-040 Backpressure: out_ready=0 while 4 words are offered -> 3 words accepted, in_ready=0, occupancy=3, outputs held stable; then out_ready=1 -> all 4 words emerge in order with no loss.
REQ-041 Bubble collapse: accept word A, idle 2 cycles, hold out_ready=0, accept B and C -> occupancy=3 with A, B, C contiguous and in order.
REQ-042 Reset mid-stream: assert reset=0 with occupancy=2 between clock edges -> out_valid=0 and occupancy=0 immediately; after release, a fresh word with amt=5 emerges correct after 3 cycles.
